// File: rtl/ooo_reg_scoreboard.sv
// ooo_reg_scoreboard: per-architectural-register busy/tag table in decode.
// Marks rd busy with its ROB tag at dispatch and clears it when the matching
// tag commits. Lookups for rs1/rs2/rd are combinational from registered state.
// Optional macro SCOREBOARD_BYPASS_EN: a lookup that hits a same-cycle matching
// commit reads not-busy, saving one stall cycle at commit.
module ooo_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int TAG_W    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             dispatch_en,
  input  logic             dispatch_wen,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic             commit_valid,
  input  logic             commit_wen,
  input  logic [REG_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             flush,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  output logic [REG_W:0]   busy_count,
  output logic             none_busy
);

  // Entry 0 exists only so lookups can index directly; it is forced to 0.
  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [REG_W:0]                 busy_count_q, busy_count_d;

  logic set_en, clr_en, inc, dec;
  logic byp_rs1, byp_rs2, byp_rd;

  assign set_en = dispatch_en && dispatch_wen && (rd != '0);
  assign clr_en = commit_valid && commit_wen && (commit_rd != '0) &&
                  busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);
  // A set of an already-busy reg adds nothing; a clear overridden by a set
  // of the same reg removes nothing.
  assign inc    = set_en && !busy_q[rd];
  assign dec    = clr_en && !(set_en && (rd == commit_rd));

`ifdef SCOREBOARD_BYPASS_EN
  assign byp_rs1 = clr_en && (rs1 == commit_rd);
  assign byp_rs2 = clr_en && (rs2 == commit_rd);
  assign byp_rd  = clr_en && (rd  == commit_rd);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
  assign byp_rd  = 1'b0;
`endif

  // Next-state: flush beats everything; within a cycle the set is applied
  // after the clear so a same-reg set wins.
  always_comb begin
    busy_d       = busy_q;
    tag_d        = tag_q;
    busy_count_d = busy_count_q;
    if (flush) begin
      busy_d       = '0;
      busy_count_d = '0;
    end else begin
      if (clr_en) busy_d[commit_rd] = 1'b0;
      if (set_en) begin
        busy_d[rd] = 1'b1;
        tag_d[rd]  = dispatch_tag;
      end
      busy_count_d = busy_count_q + {{REG_W{1'b0}}, inc} - {{REG_W{1'b0}}, dec};
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q       <= '0;
      tag_q        <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign rs1_busy   = busy_q[rs1] && !byp_rs1;
  assign rs2_busy   = busy_q[rs2] && !byp_rs2;
  assign rd_busy    = busy_q[rd]  && !byp_rd;
  assign rs1_tag    = tag_q[rs1];
  assign rs2_tag    = tag_q[rs2];
  assign busy_count = busy_count_q;
  assign none_busy  = (busy_count_q == '0);

  // Counter stays within [0, NUM_REGS-1].
  a_cnt_max: assert property (@(posedge CLK) disable iff (RST)
    busy_count_q <= (REG_W+1)'(NUM_REGS-1));
  a_cnt_underflow: assert property (@(posedge CLK) disable iff (RST)
    !(flush == 1'b0 && dec && !inc && busy_count_q == '0));

endmodule
